// File: rtl/barrett_reduce_vec.sv
// Vector modular reducer: latches N signed elements plus a modulus, then
// reduces P lanes per cycle with a Barrett quotient estimate and one fix-up.
module barrett_reduce_vec #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int WW = 2 * W,
    parameter int P  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0][WW-1:0] in_vec,
    input  logic [W-1:0]         q_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0][W-1:0]  out_vec,
    output logic                 out_err
);

    localparam int NB = N / P;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    generate
        if ((N % P) != 0 || P > N) begin : g_bad_p
            $error("barrett_reduce_vec: P must divide N and not exceed it");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                state;
    logic [BW-1:0]         beat;
    logic [N-1:0][WW-1:0]  x_q;
    logic [W-1:0]          q_q;
    logic [WW-1:0]         mu_q;
    logic [WW-1:0]         mu_next;
    logic [P-1:0][WW-1:0]  lane_x;
    logic [P-1:0][W-1:0]   lane_r;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // mu = floor(2^WW / q); with K = WW the estimate is off by at most one q
    always_comb begin
        logic [WW:0] qd;
        qd      = (q_in < W'(2)) ? (WW+1)'(2) : (WW+1)'(q_in);
        mu_next = WW'(((WW+1)'(1) << WW) / qd);
    end

    function automatic logic [W-1:0] reduce(
        input logic [WW-1:0] x,
        input logic [W-1:0]  q,
        input logic [WW-1:0] mu
    );
        logic          neg;
        logic [WW-1:0] a;
        logic [WW-1:0] qhat;
        logic [W:0]    r;
        neg  = x[WW-1];
        a    = neg ? -x : x;
        qhat = WW'(({WW'(0), a} * {WW'(0), mu}) >> WW);
        // true remainder lies in [0, 2q) so W+1 bits hold it exactly
        r    = (W+1)'(a) - (W+1)'(qhat) * (W+1)'(q);
        if (r >= (W+1)'(q)) r = r - (W+1)'(q);
        if (neg && r != '0) r = (W+1)'(q) - r;
        return W'(r);
    endfunction

    always_comb begin
        lane_x = '0;
        for (int i = 0; i < N; i++) begin
            if (i / P == int'(beat)) lane_x[i % P] = x_q[i];
        end
    end

    always_comb begin
        lane_r = '0;
        for (int j = 0; j < P; j++) begin
            lane_r[j] = reduce(lane_x[j], q_q, mu_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            beat    <= '0;
            out_vec <= '0;
            out_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q     <= in_vec;
                        q_q     <= q_in;
                        mu_q    <= mu_next;
                        out_err <= (q_in < W'(2));
                        beat    <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < N; i++) begin
                        if (i / P == int'(beat))
                            out_vec[i] <= out_err ? '0 : lane_r[i % P];
                    end
                    beat <= beat + BW'(1);
                    if (beat == BW'(NB - 1)) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_barrett_reduce_vec.sv
// Directed bench for barrett_reduce_vec with N=8, P=2, W=8, WW=16.
module tb_barrett_reduce_vec;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [7:0][15:0]    in_vec;
    logic [7:0]          q_in;
    logic                out_valid;
    logic                out_ready;
    logic [7:0][7:0]     out_vec;
    logic                out_err;

    int checks   = 0;
    int failures = 0;

    barrett_reduce_vec #(.N(8), .W(8), .WW(16), .P(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .q_in      (q_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int xs[8], input int q);
        for (int i = 0; i < 8; i++) in_vec[i] = 16'(xs[i]);
        q_in = 8'(q);
    endtask

    task automatic accept(input int xs[8], input int q);
        load(xs, q);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
        checks++;
        if (out_vec !== '0 || out_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: vec=%h err=%b want 0 0", out_vec, out_err);
        end
    endtask

    task automatic test_latency_signed();
        int xs[8] = '{-1, -32768, 32767, 0, 17, -17, 16, -18};
        int ex[8] = '{16, 8, 8, 0, 0, 0, 16, 16};
        int ys[8] = '{5, 5, 5, 5, 5, 5, 5, 5};
        accept(xs, 17);
        load(ys, 3);
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL lat_busy e%0d: vld=%b rdy=%b want 0 0", e, out_valid, in_ready);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL lat_done: vld=%b rdy=%b want 1 0", out_valid, in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_vec[i] !== 8'(ex[i])) begin
                failures++;
                $display("FAIL signed[%0d]: got %0d want %0d", i, out_vec[i], ex[i]);
            end
        end
        checks++;
        if (out_err !== 1'b0) begin
            failures++;
            $display("FAIL signed_err: got %b want 0", out_err);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_idle: rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_modulus_switch();
        int xs[8] = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
        accept(xs, 251);
        load(xs, 13);
        in_valid = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_vec[i] !== 8'd247) begin
                failures++;
                $display("FAIL q251[%0d]: got %0d want 247", i, out_vec[i]);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL no_accept_on_done: rdy=%b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: rdy=%b want 0", in_ready);
        end
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL q13_valid: vld=%b want 1", out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_vec[i] !== 8'd12) begin
                failures++;
                $display("FAIL q13[%0d]: got %0d want 12", i, out_vec[i]);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_edge_moduli();
        int xa[8] = '{-32768, 32767, 255, -255, 254, -1, 0, 510};
        int ea[8] = '{127, 127, 0, 0, 254, 254, 0, 0};
        int xb[8] = '{-32768, -1, 1, 3, 2, -2, 7, -7};
        int eb[8] = '{0, 1, 1, 1, 0, 0, 1, 1};
        accept(xa, 255);
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_vec[i] !== 8'(ea[i])) begin
                failures++;
                $display("FAIL q255[%0d]: got %0d want %0d", i, out_vec[i], ea[i]);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        accept(xb, 2);
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_vec[i] !== 8'(eb[i])) begin
                failures++;
                $display("FAIL q2[%0d]: got %0d want %0d", i, out_vec[i], eb[i]);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int xs[8] = '{-1, -32768, 32767, 0, 17, -17, 16, -18};
        int ex[8] = '{16, 8, 8, 0, 0, 0, 16, 16};
        accept(xs, 17);
        repeat (4) tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hs c%0d: vld=%b rdy=%b want 1 0", c, out_valid, in_ready);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (out_vec[i] !== 8'(ex[i])) begin
                    failures++;
                    $display("FAIL bp_vec c%0d[%0d]: got %0d want %0d", c, i, out_vec[i], ex[i]);
                end
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int xs[8] = '{100, 100, 100, 100, 100, 100, 100, 100};
        int ys[8] = '{-1, -32768, 32767, 0, 17, -17, 16, -18};
        int ex[8] = '{16, 8, 8, 0, 0, 0, 16, 16};
        accept(xs, 7);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_vec !== '0) begin
            failures++;
            $display("FAIL mid_reset: rdy=%b vld=%b vec=%h want 1 0 0", in_ready, out_valid, out_vec);
        end
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_discard: vld=%b want 0", out_valid);
        end
        accept(ys, 17);
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_after_valid: vld=%b want 1", out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_vec[i] !== 8'(ex[i])) begin
                failures++;
                $display("FAIL mid_after[%0d]: got %0d want %0d", i, out_vec[i], ex[i]);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_bad_q();
        int xs[8] = '{5, -5, 100, -100, 1, 0, 32767, -32768};
        int ex[8] = '{5, 12, 15, 2, 1, 0, 8, 8};
        accept(xs, 1);
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_early: vld=%b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_vec !== '0) begin
            failures++;
            $display("FAIL err_q1: vld=%b err=%b vec=%h want 1 1 0", out_valid, out_err, out_vec);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        accept(xs, 17);
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: vld=%b err=%b want 1 0", out_valid, out_err);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_vec[i] !== 8'(ex[i])) begin
                failures++;
                $display("FAIL err_next[%0d]: got %0d want %0d", i, out_vec[i], ex[i]);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_vec    = '0;
        q_in      = '0;
        test_reset();
        test_latency_signed();
        test_modulus_switch();
        test_edge_moduli();
        test_backpressure();
        test_reset_mid();
        test_bad_q();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/barrett_reduce_vec.md
BARRETT_REDUCE_VEC -- requirements
Module: barrett_reduce_vec

Interface
REQ-001 SHALL have parameter N, default N_SLOTS_L: vector length (element count).
REQ-002 SHALL have parameter W, default W_BITS_L: residue width in bits.
REQ-003 SHALL have parameter WW, default 2*W_BITS_L: input element width, signed two's complement.
REQ-004 SHALL have parameter P, default 4: lanes reduced per cycle; N mod P != 0 or P > N SHALL fail elaboration.
REQ-005 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1: in_vec and q_in are valid.
REQ-008 SHALL have port in_ready, output, 1: block can accept a vector.
REQ-009 SHALL have port in_vec, input, N x WW signed: elements to reduce.
REQ-010 SHALL have port q_in, input, W unsigned: modulus for this vector (per-vector RNS limb select).
REQ-011 SHALL have port out_valid, output, 1: out_vec and out_err are valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port out_vec, output, vec_t (N x W): reduced residues.
REQ-014 SHALL have port out_err, output, 1: latched q_in was < 2.

Function
REQ-015 SHALL implement states IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 SHALL accept a vector on an edge with in_valid && in_ready; at that edge it SHALL latch all N elements and q_in, clear beat counter, and enter BUSY.
REQ-017 In BUSY, each edge SHALL reduce beat k: elements k*P .. k*P+P-1; it SHALL write them to the output register and increment k.
REQ-018 The edge that processes beat N/P-1 SHALL move to DONE, so out_valid rises exactly N/P cycles after the accept edge.
REQ-019 In DONE, out_vec and out_err SHALL hold stable until an edge with out_ready=1, which SHALL return to IDLE.
REQ-020 A vector SHALL NOT be accepted in the same edge as a DONE handshake; throughput SHALL be one vector per N/P+2 cycles.
REQ-021 in_valid in BUSY/DONE SHALL be ignored; in_vec/q_in changes after accept SHALL NOT affect results.
REQ-022 Per element x, result SHALL equal the mathematical residue r in [0, q-1] with x = m*q + r.
REQ-023 This SHALL hold for negative x, including x = -2^(WW-1), and for x that are exact multiples of q, which yield 0.
REQ-024 The result SHALL be zero-extended/truncated exactly to W bits with no overflow for any q in [2, 2^W-1].
REQ-025 If latched q < 2, all out_vec elements SHALL be 0 and out_err SHALL be 1; the FSM timing SHALL be unchanged.
REQ-026 Internal products (Barrett or equivalent) SHALL be sized so no intermediate overflows for any legal x, q.

Reset
REQ-027 While reset=1 at an edge: state->IDLE, beat counter->0, out_vec->all 0, out_err->0; thus in_ready=1, out_valid=0 after that edge.
REQ-028 Reset SHALL take priority over all handshakes, including mid-BUSY or in DONE; a partial vector SHALL be discarded and never emitted.

Verification (N=8, P=2, W=8, WW=16 unless noted)
REQ-029 Latency: accept at edge 0 with q=17 -> out_valid first high after edge 4; in_ready low from edge 0 until the edge after the out handshake.
REQ-030 Signed edges with q=17: x = {-1, -32768, 32767, 0, 17, -17, 16, -18} -> {16, 8, 8, 0, 0, 0, 16, 16}.
REQ-031 Modulus switch: back-to-back vectors x=1000 with q=251 then q=13 -> 247 then 12; each result uses its own latched q.
REQ-032 Backpressure: out_ready low 5 cycles in DONE -> out_vec constant, out_valid high, in_ready low; accepting on edge 5 returns to IDLE.
REQ-033 Reset at beat 2 of BUSY -> next cycle in_ready=1, out_valid=0, out_vec=0; a following vector completes normally.
REQ-034 q_in=1 -> out_vec all 0, out_err=1 at the normal out_valid time; the next vector with q=17 -> out_err=0.
